// File: rtl/rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the eight-way round-robin arbiter:
//   - state_t            : arbiter FSM states (IDLE, GRANT)
//   - HOLD_MAX_DEFAULT   : default hold limit before a waiting requester may
//                          preempt the current owner
//   - CNT_W_DEFAULT      : default hold counter width
//   - SEG_DIGIT / SEG_BLANK : active-low 7-segment codes, bit order gfedcba
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int HOLD_MAX_DEFAULT = 15;
    localparam int CNT_W_DEFAULT    = 8;

    // Active-low segment patterns for digits 0..7, bits gfedcba.
    localparam logic [6:0] SEG_DIGIT [0:7] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : arb_pkg

// File: rtl/rr_arbiter8_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_if
// Request/grant bundle between the board inputs and the arbiter.
//   req       [7:0] : level-sensitive request vector, bit i = requester i
//   gnt       [7:0] : one-hot grant, all zero when idle
//   gnt_idx   [2:0] : binary index of the owner, 0 when idle
//   gnt_valid       : high while a grant is active
//   seg       [6:0] : active-low 7-segment code of gnt_idx (blank when idle)
// master drives req and observes the grant; slave is the arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter8_if;

    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [6:0] seg;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  seg
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output seg
    );

endinterface : rr_arbiter8_if

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin winner search over eight requesters.
//   req   [7:0] : request vector
//   start [2:0] : first index considered; the search wraps mod 8
//   mask  [7:0] : requesters excluded from the search
//   idx   [2:0] : winning index (0 when nothing qualifies)
//   found       : high when some unmasked request exists
// The candidate vector is rotated right by start so that the lowest set
// bit of the rotated vector is the first requester at or after start;
// adding start back (3-bit wrap) recovers the absolute index.
// ---------------------------------------------------------------------------
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] start,
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       found
);

    logic [7:0]  cand;
    logic [15:0] doubled;
    logic [7:0]  rot;
    logic [2:0]  offset;

    // Rotate, find the lowest set bit, then undo the rotation.
    always_comb begin
        cand    = req & ~mask;
        doubled = {cand, cand} >> start;
        rot     = doubled[7:0];
        found   = 1'b0;
        offset  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = 3'(i);
            end
        end
        idx = found ? (offset + start) : 3'd0;
    end

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Eight-requester round-robin arbiter with bounded hold time.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter8_if.slave (req in; gnt, gnt_idx, gnt_valid, seg out)
// Parameters:
//   HOLD_MAX : cycles after grant issue at which a waiting requester may
//              preempt the owner (1..255); owner tenure under contention is
//              HOLD_MAX+1 cycles
//   CNT_W    : hold counter width, must be able to represent HOLD_MAX
// All outputs are registered.
// ---------------------------------------------------------------------------
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter8_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [7:0]       gnt_q;
    logic [2:0]       gnt_idx_q;
    logic             gnt_valid_q;
    logic [6:0]       seg_q;

    logic [7:0]       owner_mask;
    logic [2:0]       next_ptr;
    logic             owner_req;
    logic             others;
    logic [2:0]       pick_start;
    logic [7:0]       pick_mask;
    logic [2:0]       pick_idx;
    logic             pick_found;

    // Search setup: in IDLE search from ptr with no mask; while granting,
    // search from the slot after the owner with the owner masked. Masking the
    // owner is harmless on release since its request is already low.
    always_comb begin
        owner_mask = 8'b1 << gnt_idx_q;
        next_ptr   = gnt_idx_q + 3'd1;
        owner_req  = |(bus.req & owner_mask);
        others     = |(bus.req & ~owner_mask);
        pick_start = ptr;
        pick_mask  = 8'h00;
        if (state == GRANT) begin
            pick_start = next_ptr;
            pick_mask  = owner_mask;
        end
    end

    rr_pick8 u_pick (
        .req   (bus.req),
        .start (pick_start),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Arbiter FSM with registered outputs. A new grant always loads
    // gnt/gnt_idx/seg together from the picker so they can never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= '0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            seg_q       <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        hold_cnt    <= '0;
                        gnt_q       <= 8'b1 << pick_idx;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        seg_q       <= SEG_DIGIT[pick_idx];
                    end
                end

                GRANT: begin
                    if (!owner_req) begin
                        // Owner released: hand off directly or fall idle.
                        ptr      <= next_ptr;
                        hold_cnt <= '0;
                        if (pick_found) begin
                            gnt_q       <= 8'b1 << pick_idx;
                            gnt_idx_q   <= pick_idx;
                            gnt_valid_q <= 1'b1;
                            seg_q       <= SEG_DIGIT[pick_idx];
                        end else begin
                            state       <= IDLE;
                            gnt_q       <= 8'h00;
                            gnt_idx_q   <= 3'd0;
                            gnt_valid_q <= 1'b0;
                            seg_q       <= SEG_BLANK;
                        end
                    end else if ((hold_cnt == HOLD_LIMIT) && others) begin
                        // Hold time expired with someone waiting: preempt.
                        ptr         <= next_ptr;
                        hold_cnt    <= '0;
                        gnt_q       <= 8'b1 << pick_idx;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        seg_q       <= SEG_DIGIT[pick_idx];
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        // Saturating count so a lone owner never wraps.
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.seg       = seg_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
// Scoreboard bench for rr_arbiter8. Two arbiters run side by side on the
// same request vector: dut_a with the default hold limit of 15 and dut_b
// with a hold limit of 3. Each stimulus cycle pushes the hand-computed grant
// expected from both DUTs after the next rising edge; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

    logic clk;
    logic rst;

    rr_arbiter8_if if_a ();
    rr_arbiter8_if if_b ();

    rr_arbiter8 #(.HOLD_MAX(15), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    rr_arbiter8 #(.HOLD_MAX(3), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    typedef struct {
        string      name;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    logic [6:0] seg_ref [0:7];

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one DUT's outputs against an expected one-hot grant; index,
    // valid and segment code are derived from that grant.
    task automatic checkOutput(input string nm, input logic [7:0] g,
                               input logic [2:0] ix, input logic v,
                               input logic [6:0] sg, input logic [7:0] eg);
        logic [2:0] eix;
        logic       ev;
        logic [6:0] esg;
        eix = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eg[i]) eix = 3'(i);
        end
        ev  = (eg != 8'h00);
        esg = ev ? seg_ref[eix] : 7'b1111111;

        checks++;
        if (g !== eg) begin
            errors++;
            $display("[TB] FAIL %s gnt got %h want %h", nm, g, eg);
        end
        checks++;
        if (ix !== eix) begin
            errors++;
            $display("[TB] FAIL %s gnt_idx got %0d want %0d", nm, ix, eix);
        end
        checks++;
        if (v !== ev) begin
            errors++;
            $display("[TB] FAIL %s gnt_valid got %b want %b", nm, v, ev);
        end
        checks++;
        if (sg !== esg) begin
            errors++;
            $display("[TB] FAIL %s seg got %b want %b", nm, sg, esg);
        end
    endtask

    // Monitor: on every falling edge, retire the oldest pending expectation
    // against both DUTs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.name, "_a"}, if_a.gnt, if_a.gnt_idx,
                        if_a.gnt_valid, if_a.seg, e.exp_a);
            checkOutput({e.name, "_b"}, if_b.gnt, if_b.gnt_idx,
                        if_b.gnt_valid, if_b.seg, e.exp_b);
        end
    end

    // Drive one cycle of inputs just after the falling edge and queue the
    // grant each DUT must show after the following rising edge.
    task automatic applyStimulus(input logic r, input logic [7:0] rq,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        rst      = r;
        if_a.req = rq;
        if_b.req = rq;
        e.name   = nm;
        e.exp_a  = ea;
        e.exp_b  = eb;
        exp_q.push_back(e);
    endtask

    // Directed sequence; expected grants are worked out by hand from the
    // round-robin rules (search start, owner mask, hold limit).
    initial begin
        int drain;
        checks = 0;
        errors = 0;
        seg_ref[0] = 7'b1000000;
        seg_ref[1] = 7'b1111001;
        seg_ref[2] = 7'b0100100;
        seg_ref[3] = 7'b0110000;
        seg_ref[4] = 7'b0011001;
        seg_ref[5] = 7'b0010010;
        seg_ref[6] = 7'b0000010;
        seg_ref[7] = 7'b1111000;
        rst      = 1'b1;
        if_a.req = 8'h00;
        if_b.req = 8'h00;

        // Reset with all requests high: outputs stay cleared, then req 0 wins.
        applyStimulus(1'b1, 8'hFF, 8'h00, 8'h00, "rst_hold0");
        applyStimulus(1'b1, 8'hFF, 8'h00, 8'h00, "rst_hold1");
        applyStimulus(1'b0, 8'hFF, 8'h01, 8'h01, "rst_release");

        // Single requester 5 holds indefinitely past any hold limit.
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, "single_rst");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 8'h20, 8'h20, 8'h20, "single_hold");
        end

        // Release handoff 2 -> 6 without an idle bubble.
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, "handoff_rst");
        applyStimulus(1'b0, 8'h04, 8'h04, 8'h04, "handoff_own2");
        applyStimulus(1'b0, 8'h44, 8'h04, 8'h04, "handoff_wait6");
        applyStimulus(1'b0, 8'h40, 8'h40, 8'h40, "handoff_to6");

        // Owner 6 releases with only 4 left: search from 7 wraps to 4.
        applyStimulus(1'b0, 8'h10, 8'h10, 8'h10, "wrap_to4");
        // Owner 4 releases, nobody left: idle with ptr = 5.
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, "all_release");
        // From ptr 5, requesters 0 and 4: search 5,6,7,0 picks 0.
        applyStimulus(1'b0, 8'h11, 8'h01, 8'h01, "ptr_wrap_pick0");
        applyStimulus(1'b0, 8'h10, 8'h10, 8'h10, "release0_to4");

        // Owner 6 active, then reset for one cycle; ptr returns to 0.
        applyStimulus(1'b0, 8'h40, 8'h40, 8'h40, "midrst_own6");
        applyStimulus(1'b1, 8'h40, 8'h00, 8'h00, "midrst_pulse");
        applyStimulus(1'b0, 8'h41, 8'h01, 8'h01, "midrst_pick0");

        // Fairness with requesters 0 and 7 constantly asserted:
        // hold 3 alternates every 4 cycles, hold 15 keeps 0 for 16 cycles.
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, "fair_rst");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 8'h81,
                          (k < 16) ? 8'h01 : 8'h80,
                          (((k / 4) % 2) == 0) ? 8'h01 : 8'h80,
                          "fair");
        end

        // Let the monitor retire everything, bounded.
        drain = 0;
        while ((exp_q.size() != 0) && (drain < 10)) begin
            @(negedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending got %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter8
